uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 132 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_frame_tx among NUM_REQ frame sources,
// with a saturating watchdog on the transmitter's completion pulse.
module uart_tx_arbiter #(
    parameter  int NUM_REQ     = 4,
    parameter  int FRAME_WD    = 8,
    parameter  int TIMEOUT_CYC = 100_000,
    localparam int IDW         = $clog2(NUM_REQ),
    localparam int CW          = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic [NUM_REQ-1:0]           req_i,
    input  logic [NUM_REQ*FRAME_WD-1:0]  req_data_i,
    output logic [NUM_REQ-1:0]           gnt_o,
    output logic [NUM_REQ-1:0]           done_o,
    output logic                         timeout_o,
    output logic                         busy_o,
    output logic                         frame_en_o,
    output logic [FRAME_WD-1:0]          data_frame_o,
    input  logic                         tx_done_i,
    output logic [1:0]                   state_o,
    output logic [IDW-1:0]               ptr_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_GAP  = 2'd2
    } state_e;

    state_e                state_q;
    logic [IDW-1:0]        ptr_q;
    logic [IDW-1:0]        cur_id_q;
    logic [CW-1:0]         cnt_q;
    logic [NUM_REQ-1:0]    gnt_q;
    logic [NUM_REQ-1:0]    done_q;
    logic                  timeout_q;
    logic                  busy_q;
    logic                  frame_en_q;
    logic [FRAME_WD-1:0]   data_q;

    logic [IDW:0]          idx_d;
    logic [IDW-1:0]        sel_id_d;
    logic                  sel_found_d;
    logic [IDW-1:0]        ptr_d;

    // Scan from ptr upward with an explicit wrap so non-power-of-two counts work.
    always_comb begin
        idx_d       = '0;
        sel_id_d    = '0;
        sel_found_d = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_d = {1'b0, ptr_q} + (IDW+1)'(i);
            if (idx_d >= (IDW+1)'(NUM_REQ)) begin
                idx_d = idx_d - (IDW+1)'(NUM_REQ);
            end
            if (!sel_found_d && req_i[idx_d[IDW-1:0]]) begin
                sel_found_d = 1'b1;
                sel_id_d    = idx_d[IDW-1:0];
            end
        end
    end

    always_comb begin
        ptr_d = (cur_id_q == IDW'(NUM_REQ - 1)) ? '0 : cur_id_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            cur_id_q   <= '0;
            cnt_q      <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
            frame_en_q <= 1'b0;
            data_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (sel_found_d) begin
                        cur_id_q   <= sel_id_d;
                        data_q     <= req_data_i[sel_id_d*FRAME_WD +: FRAME_WD];
                        gnt_q      <= NUM_REQ'(1) << sel_id_d;
                        frame_en_q <= 1'b1;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    gnt_q      <= '0;
                    frame_en_q <= 1'b0;
                    if (cnt_q != CW'(TIMEOUT_CYC)) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    // Completion takes priority over an expiring watchdog.
                    if (tx_done_i) begin
                        done_q  <= NUM_REQ'(1) << cur_id_q;
                        ptr_q   <= ptr_d;
                        state_q <= S_GAP;
                    end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                        timeout_q <= 1'b1;
                        ptr_q     <= ptr_d;
                        state_q   <= S_GAP;
                    end
                end
                S_GAP: begin
                    done_q    <= '0;
                    timeout_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt_o        = gnt_q;
    assign done_o       = done_q;
    assign timeout_o    = timeout_q;
    assign busy_o       = busy_q;
    assign frame_en_o   = frame_en_q;
    assign data_frame_o = data_q;
    assign state_o      = state_q;
    assign ptr_o        = ptr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: grant order, data capture, completion,
// watchdog, boundary pulses and mid-frame reset, checked with immediate assertions.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int FRAME_WD = 8;
    localparam int TMO      = 16;

    localparam logic [31:0] ST_IDLE = 32'd0;
    localparam logic [31:0] ST_WAIT = 32'd1;
    localparam logic [31:0] ST_GAP  = 32'd2;

    logic                        clk;
    logic                        rst_n;
    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ*FRAME_WD-1:0] req_data;
    logic [NUM_REQ-1:0]          gnt;
    logic [NUM_REQ-1:0]          done;
    logic                        timeout;
    logic                        busy;
    logic                        frame_en;
    logic [FRAME_WD-1:0]         data_frame;
    logic                        tx_done;
    logic [1:0]                  state;
    logic [1:0]                  ptr;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .FRAME_WD    (FRAME_WD),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .req_i        (req),
        .req_data_i   (req_data),
        .gnt_o        (gnt),
        .done_o       (done),
        .timeout_o    (timeout),
        .busy_o       (busy),
        .frame_en_o   (frame_en),
        .data_frame_o (data_frame),
        .tx_done_i    (tx_done),
        .state_o      (state),
        .ptr_o        (ptr)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_lane(input int id, input logic [7:0] val);
        req_data[id*FRAME_WD +: FRAME_WD] = val;
    endtask

    task automatic expect_grant(input string tag, input int id, input logic [7:0] data);
        chk({tag, "_gnt"},   gnt, 32'(1) << id);
        chk({tag, "_fen"},   frame_en, 1);
        chk({tag, "_data"},  data_frame, data);
        chk({tag, "_busy"},  busy, 1);
        chk({tag, "_state"}, state, ST_WAIT);
    endtask

    // Holds n cycles in WAIT, pulses tx_done, checks GAP then IDLE.
    task automatic finish_frame(input string tag, input int id, input logic [7:0] data,
                                input int n);
        for (int c = 0; c < n; c++) begin
            tick();
            chk({tag, "_hold_gnt"},  gnt, 0);
            chk({tag, "_hold_fen"},  frame_en, 0);
            chk({tag, "_hold_data"}, data_frame, data);
            chk({tag, "_hold_busy"}, busy, 1);
        end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk({tag, "_done"},       done, 32'(1) << id);
        chk({tag, "_done_tmo"},   timeout, 0);
        chk({tag, "_done_state"}, state, ST_GAP);
        chk({tag, "_done_busy"},  busy, 1);
        chk({tag, "_done_data"},  data_frame, data);
        tick();
        chk({tag, "_idle_done"},  done, 0);
        chk({tag, "_idle_state"}, state, ST_IDLE);
        chk({tag, "_idle_busy"},  busy, 0);
        chk({tag, "_idle_fen"},   frame_en, 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        req      = '0;
        req_data = '0;
        tx_done  = 1'b0;
        tick();
        tick();

        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fen", frame_en, 0);
        chk("rst_data", data_frame, 0);
        chk("rst_ptr", ptr, 0);
        chk("rst_state", state, ST_IDLE);

        // Simultaneous requests 1 and 3: order 1,3,1,3, next grant 3 cycles after tx_done
        rst_n = 1'b1;
        req   = 4'b1010;
        set_lane(1, 8'h5A);
        set_lane(3, 8'hC3);
        tick();
        expect_grant("alt1", 1, 8'h5A);
        finish_frame("alt1", 1, 8'h5A, 2);
        tick();
        expect_grant("alt2", 3, 8'hC3);
        finish_frame("alt2", 3, 8'hC3, 3);
        tick();
        expect_grant("alt3", 1, 8'h5A);
        finish_frame("alt3", 1, 8'h5A, 1);
        tick();
        expect_grant("alt4", 3, 8'hC3);
        chk("alt4_ptr", ptr, 2);

        // Fairness: all four requesting, switched while WAIT holds the old frame
        req = 4'b1111;
        set_lane(0, 8'h10);
        set_lane(1, 8'h21);
        set_lane(2, 8'h32);
        set_lane(3, 8'h43);
        finish_frame("alt4", 3, 8'hC3, 2);
        chk("fair_ptr0", ptr, 0);
        tick();
        expect_grant("fair0", 0, 8'h10);
        finish_frame("fair0", 0, 8'h10, 2);
        tick();
        expect_grant("fair1", 1, 8'h21);
        finish_frame("fair1", 1, 8'h21, 2);
        tick();
        expect_grant("fair2", 2, 8'h32);
        finish_frame("fair2", 2, 8'h32, 2);
        tick();
        expect_grant("fair3", 3, 8'h43);
        finish_frame("fair3", 3, 8'h43, 2);
        tick();
        expect_grant("fair4", 0, 8'h10);

        // Single request from requester 2 with data A5
        req = 4'b0100;
        set_lane(2, 8'hA5);
        finish_frame("fair4", 0, 8'h10, 2);
        tick();
        expect_grant("single", 2, 8'hA5);
        req = 4'b0000;
        finish_frame("single", 2, 8'hA5, 4);
        chk("single_ptr", ptr, 3);

        // Spurious tx_done while IDLE
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("spur_done", done, 0);
        chk("spur_gnt", gnt, 0);
        chk("spur_busy", busy, 0);
        chk("spur_state", state, ST_IDLE);
        chk("spur_data", data_frame, 8'hA5);
        tick();
        chk("spur_done2", done, 0);
        chk("spur_ptr", ptr, 3);

        // Watchdog: launch in cycle 1, timeout in cycle 1+TMO
        req = 4'b0001;
        set_lane(0, 8'h77);
        tick();
        expect_grant("wd", 0, 8'h77);
        req = 4'b0000;
        for (int c = 2; c <= TMO; c++) begin
            tick();
            chk("wd_no_timeout", timeout, 0);
            chk("wd_busy", busy, 1);
        end
        tick();
        chk("wd_timeout", timeout, 1);
        chk("wd_no_done", done, 0);
        chk("wd_state", state, ST_GAP);
        chk("wd_ptr", ptr, 1);
        tick();
        chk("wd_timeout_clr", timeout, 0);
        chk("wd_idle", state, ST_IDLE);
        chk("wd_idle_busy", busy, 0);
        chk("wd_hold_data", data_frame, 8'h77);

        // Pointer advanced: requester 1 wins over 0; tx_done lands on the threshold cycle
        req = 4'b0011;
        set_lane(1, 8'h3C);
        tick();
        expect_grant("bnd", 1, 8'h3C);
        req = 4'b0000;
        finish_frame("bnd", 1, 8'h3C, TMO - 1);
        chk("bnd_ptr", ptr, 2);

        // Reset in mid-WAIT
        req = 4'b0100;
        set_lane(2, 8'hE7);
        tick();
        expect_grant("mrst", 2, 8'hE7);
        req = 4'b1101;
        tick();
        tick();
        tick();
        chk("mrst_pre_state", state, ST_WAIT);
        rst_n = 1'b0;
        tick();
        chk("mrst_gnt", gnt, 0);
        chk("mrst_done", done, 0);
        chk("mrst_timeout", timeout, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_fen", frame_en, 0);
        chk("mrst_data", data_frame, 0);
        chk("mrst_ptr", ptr, 0);
        chk("mrst_state", state, ST_IDLE);
        rst_n   = 1'b1;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("mrst_no_done", done, 0);
        expect_grant("mrst_r0", 0, 8'h77);
        finish_frame("mrst_r0", 0, 8'h77, 2);
        tick();
        expect_grant("mrst_r2", 2, 8'hE7);
        req = 4'b0000;
        finish_frame("mrst_r2", 2, 8'hE7, 1);
        tick();
        chk("end_state", state, ST_IDLE);
        chk("end_gnt", gnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
